// File: rtl/usb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : usb_dma_engine
// Purpose  : Byte-stream DMA between USB RX/TX FIFOs and a 16-bit memory port.
// Revision : 1.0
// ============================================================================
module usb_dma_engine (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        direction_i,
    input  logic [31:0] address_i,
    input  logic [26:0] length_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [26:0] remaining_o,
    input  logic        rx_empty_i,
    input  logic [7:0]  rx_rdata_i,
    output logic        rx_read_o,
    input  logic        tx_full_i,
    output logic        tx_write_o,
    output logic [7:0]  tx_wdata_o,
    output logic        mem_request_o,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RX_HI     = 3'd1;
    localparam logic [2:0] S_RX_LO     = 3'd2;
    localparam logic [2:0] S_MEM_WRITE = 3'd3;
    localparam logic [2:0] S_MEM_READ  = 3'd4;
    localparam logic [2:0] S_TX_HI     = 3'd5;
    localparam logic [2:0] S_TX_LO     = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [26:0] remaining_q, remaining_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        tx_write_q, tx_write_d;
    logic [7:0]  tx_wdata_q, tx_wdata_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic        abort_q, abort_d;
    logic        w_finish;
    logic        w_rx_pop;

    assign w_rx_pop = ((state_q == S_RX_HI) || (state_q == S_RX_LO)) && !rx_empty_i && !stop_i;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        tx_write_d  = 1'b0;
        tx_wdata_d  = tx_wdata_q;
        req_d       = req_q;
        wr_d        = wr_q;
        abort_d     = abort_q;
        w_finish    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (length_i != 27'd0) begin
                        addr_d      = {address_i[31:1], 1'b0};
                        remaining_d = length_i;
                        busy_d      = 1'b1;
                        abort_d     = 1'b0;
                        if (direction_i) begin
                            state_d = S_MEM_READ;
                            req_d   = 1'b1;
                            wr_d    = 1'b0;
                        end else begin
                            state_d = S_RX_HI;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RX_HI: begin
                if (stop_i) begin
                    w_finish = 1'b1;
                end else if (!rx_empty_i) begin
                    wdata_d[15:8] = rx_rdata_i;
                    remaining_d   = remaining_q - 27'd1;
                    // A lone trailing byte is padded and written without waiting for RX_LO.
                    if (remaining_q == 27'd1) begin
                        wdata_d[7:0] = 8'h00;
                        state_d      = S_MEM_WRITE;
                        req_d        = 1'b1;
                        wr_d         = 1'b1;
                    end else begin
                        state_d = S_RX_LO;
                    end
                end
            end
            S_RX_LO: begin
                if (stop_i) begin
                    w_finish = 1'b1;
                end else if (!rx_empty_i) begin
                    wdata_d[7:0] = rx_rdata_i;
                    remaining_d  = remaining_q - 27'd1;
                    state_d      = S_MEM_WRITE;
                    req_d        = 1'b1;
                    wr_d         = 1'b1;
                end
            end
            S_MEM_WRITE: begin
                if (stop_i) begin
                    abort_d = 1'b1;
                end
                if (mem_ack_i) begin
                    req_d  = 1'b0;
                    addr_d = addr_q + 32'd2;
                    if (stop_i || abort_q || (remaining_q == 27'd0)) begin
                        w_finish = 1'b1;
                    end else begin
                        state_d = S_RX_HI;
                    end
                end
            end
            S_MEM_READ: begin
                if (stop_i) begin
                    abort_d = 1'b1;
                end
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    rdata_d = mem_rdata_i;
                    addr_d  = addr_q + 32'd2;
                    if (stop_i || abort_q) begin
                        w_finish = 1'b1;
                    end else begin
                        state_d = S_TX_HI;
                    end
                end
            end
            S_TX_HI: begin
                if (stop_i) begin
                    w_finish = 1'b1;
                end else if (!tx_full_i) begin
                    tx_write_d  = 1'b1;
                    tx_wdata_d  = rdata_q[15:8];
                    remaining_d = remaining_q - 27'd1;
                    if (remaining_q == 27'd1) begin
                        w_finish = 1'b1;
                    end else begin
                        state_d = S_TX_LO;
                    end
                end
            end
            S_TX_LO: begin
                if (stop_i) begin
                    w_finish = 1'b1;
                end else if (!tx_full_i) begin
                    tx_write_d  = 1'b1;
                    tx_wdata_d  = rdata_q[7:0];
                    remaining_d = remaining_q - 27'd1;
                    if (remaining_q == 27'd1) begin
                        w_finish = 1'b1;
                    end else begin
                        state_d = S_MEM_READ;
                        req_d   = 1'b1;
                        wr_d    = 1'b0;
                    end
                end
            end
            default: begin
                w_finish = 1'b1;
            end
        endcase

        if (w_finish) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= 27'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 16'd0;
            rdata_q     <= 16'd0;
            tx_write_q  <= 1'b0;
            tx_wdata_q  <= 8'd0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            tx_write_q  <= tx_write_d;
            tx_wdata_q  <= tx_wdata_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            abort_q     <= abort_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign remaining_o   = remaining_q;
    assign rx_read_o     = w_rx_pop;
    assign tx_write_o    = tx_write_q;
    assign tx_wdata_o    = tx_wdata_q;
    assign mem_request_o = req_q;
    assign mem_write_o   = wr_q;
    assign mem_address_o = addr_q;
    assign mem_wdata_o   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_dma_engine
// Purpose  : Scoreboard bench with FIFO and memory-arbiter models.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_usb_dma_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, stop, direction;
    logic [31:0] address;
    logic [26:0] length;
    logic        busy, done;
    logic [26:0] remaining;
    logic        rx_empty, rx_read, tx_full, tx_write;
    logic [7:0]  rx_rdata, tx_wdata;
    logic        mem_request, mem_write, mem_ack;
    logic [31:0] mem_address;
    logic [15:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int req_cnt  = 0;
    int ack_lat  = 0;
    bit ack_en   = 1'b1;
    bit tx_rand  = 1'b0;

    logic [7:0]  rx_q[$];
    logic [47:0] exp_wr[$];
    logic [31:0] exp_rd_addr[$];
    logic [15:0] rd_data_q[$];
    logic [7:0]  exp_tx[$];

    usb_dma_engine dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .stop_i        (stop),
        .direction_i   (direction),
        .address_i     (address),
        .length_i      (length),
        .busy_o        (busy),
        .done_o        (done),
        .remaining_o   (remaining),
        .rx_empty_i    (rx_empty),
        .rx_rdata_i    (rx_rdata),
        .rx_read_o     (rx_read),
        .tx_full_i     (tx_full),
        .tx_write_o    (tx_write),
        .tx_wdata_o    (tx_wdata),
        .mem_request_o (mem_request),
        .mem_write_o   (mem_write),
        .mem_address_o (mem_address),
        .mem_wdata_o   (mem_wdata),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // RX/TX FIFO model; pops commit on the edge where rx_read was sampled high.
    initial begin : fifo_model
        bit pend;
        pend     = 1'b0;
        rx_empty = 1'b1;
        rx_rdata = 8'h00;
        tx_full  = 1'b0;
        forever begin
            @(negedge clk);
            if (pend && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_empty = (rx_q.size() == 0);
            rx_rdata = rx_empty ? 8'h00 : rx_q[0];
            tx_full  = tx_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            if (done) done_cnt++;
            if (tx_write) begin
                if (exp_tx.size() == 0) check_eq("tx_unexpected", 64'(tx_wdata) + 64'h100, 64'h0);
                else check_eq("tx_byte", 64'(tx_wdata), 64'(exp_tx.pop_front()));
            end
            #1;
            pend = rx_read && !rst;
        end
    end

    initial begin : mem_model
        logic [47:0] e;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (mem_request && ack_en && !rst) begin
                for (int i = 0; i < ack_lat; i++) @(negedge clk);
                if (mem_request) begin
                    req_cnt++;
                    if (mem_write) begin
                        if (exp_wr.size() == 0) begin
                            check_eq("wr_unexpected", {16'h1, mem_address, mem_wdata}, 64'h0);
                        end else begin
                            e = exp_wr.pop_front();
                            check_eq("wr_addr", 64'(mem_address), 64'(e[47:16]));
                            check_eq("wr_data", 64'(mem_wdata), 64'(e[15:0]));
                        end
                        mem_rdata = 16'h0;
                    end else begin
                        if (exp_rd_addr.size() == 0) check_eq("rd_unexpected", {32'h1, mem_address}, 64'h0);
                        else check_eq("rd_addr", 64'(mem_address), 64'(exp_rd_addr.pop_front()));
                        mem_rdata = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 16'h0;
                    end
                    mem_ack = 1'b1;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    check_eq("req_drop", 64'(mem_request), 64'h0);
                end
            end
        end
    end

    task automatic start_xfer(input logic dir, input logic [31:0] a, input logic [26:0] len);
        @(negedge clk);
        direction = dir;
        address   = a;
        length    = len;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) check_eq({tag, "_timeout"}, 64'h0, 64'h1);
    endtask

    task automatic wait_req_at(input string tag, input logic [31:0] a, input int budget);
        int n;
        n = 0;
        while (!(mem_request && mem_address == a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(mem_request && mem_address == a)) check_eq({tag, "_timeout"}, 64'h0, 64'h1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int d0, r0;
        start = 1'b0; stop = 1'b0; direction = 1'b0; address = 32'h0; length = 27'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_done", 64'(done), 64'h0);
        check_eq("rst_req", 64'(mem_request), 64'h0);
        check_eq("rst_wr", 64'(mem_write), 64'h0);
        check_eq("rst_rem", 64'(remaining), 64'h0);
        check_eq("rst_addr", 64'(mem_address), 64'h0);
        check_eq("rst_wdata", 64'(mem_wdata), 64'h0);
        check_eq("rst_tx", {tx_write, rx_read, tx_wdata}, 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write 4 bytes
        foreach (rx_q[i]) rx_q.delete();
        rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
        exp_wr.push_back({32'h100, 16'h1122});
        exp_wr.push_back({32'h102, 16'h3344});
        d0 = done_cnt; r0 = req_cnt;
        start_xfer(1'b0, 32'h100, 27'd4);
        check_eq("w4_busy", 64'(busy), 64'h1);
        check_eq("w4_rem_start", 64'(remaining), 64'd4);
        wait_done("w4", d0, 200);
        check_eq("w4_busy_fall", 64'(busy), 64'h0);
        repeat (3) @(negedge clk);
        check_eq("w4_done_cnt", 64'(done_cnt - d0), 64'd1);
        check_eq("w4_rem", 64'(remaining), 64'd0);
        check_eq("w4_reqs", 64'(req_cnt - r0), 64'd2);
        check_eq("w4_left", 64'(exp_wr.size()), 64'd0);

        // Write 3 bytes at odd address
        rx_q.push_back(8'hAA); rx_q.push_back(8'hBB); rx_q.push_back(8'hCC);
        exp_wr.push_back({32'h200, 16'hAABB});
        exp_wr.push_back({32'h202, 16'hCC00});
        d0 = done_cnt; r0 = req_cnt;
        start_xfer(1'b0, 32'h201, 27'd3);
        wait_done("w3", d0, 200);
        repeat (3) @(negedge clk);
        check_eq("w3_reqs", 64'(req_cnt - r0), 64'd2);
        check_eq("w3_left", 64'(exp_wr.size()), 64'd0);
        check_eq("w3_rem", 64'(remaining), 64'd0);

        // Read 3 bytes with slow ack and TX back-pressure
        ack_lat = 3; tx_rand = 1'b1;
        exp_rd_addr.push_back(32'h0); exp_rd_addr.push_back(32'h2);
        rd_data_q.push_back(16'h1234); rd_data_q.push_back(16'h5678);
        exp_tx.push_back(8'h12); exp_tx.push_back(8'h34); exp_tx.push_back(8'h56);
        d0 = done_cnt; r0 = req_cnt;
        start_xfer(1'b1, 32'h0, 27'd3);
        wait_done("r3", d0, 400);
        repeat (4) @(negedge clk);
        check_eq("r3_reqs", 64'(req_cnt - r0), 64'd2);
        check_eq("r3_tx_left", 64'(exp_tx.size()), 64'd0);
        check_eq("r3_done_cnt", 64'(done_cnt - d0), 64'd1);
        ack_lat = 0; tx_rand = 1'b0;

        // Abort during second write of an eight-word transfer
        ack_lat = 4;
        for (int i = 0; i < 16; i++) rx_q.push_back(8'(8'h40 + i));
        exp_wr.push_back({32'h400, 16'h4041});
        exp_wr.push_back({32'h402, 16'h4243});
        d0 = done_cnt; r0 = req_cnt;
        start_xfer(1'b0, 32'h400, 27'd16);
        wait_req_at("ab_req2", 32'h402, 200);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("ab", d0, 200);
        repeat (6) @(negedge clk);
        check_eq("ab_rem", 64'(remaining), 64'd12);
        check_eq("ab_reqs", 64'(req_cnt - r0), 64'd2);
        check_eq("ab_rx_left", 64'(rx_q.size()), 64'd12);
        check_eq("ab_done_cnt", 64'(done_cnt - d0), 64'd1);
        check_eq("ab_busy", 64'(busy), 64'h0);
        rx_q.delete();
        ack_lat = 0;
        repeat (2) @(negedge clk);

        // Address wrap plus start-while-busy
        rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03); rx_q.push_back(8'h04);
        exp_wr.push_back({32'hFFFF_FFFE, 16'h0102});
        exp_wr.push_back({32'h0000_0000, 16'h0304});
        d0 = done_cnt; r0 = req_cnt;
        start_xfer(1'b0, 32'hFFFF_FFFE, 27'd4);
        start_xfer(1'b1, 32'h500, 27'd2);
        check_eq("wr_busy_guard", 64'(busy), 64'h1);
        wait_done("wrap", d0, 200);
        repeat (5) @(negedge clk);
        check_eq("wrap_reqs", 64'(req_cnt - r0), 64'd2);
        check_eq("wrap_left", 64'(exp_wr.size()), 64'd0);
        check_eq("wrap_busy", 64'(busy), 64'h0);
        check_eq("wrap_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Zero-length start
        d0 = done_cnt; r0 = req_cnt;
        start_xfer(1'b0, 32'h700, 27'd0);
        check_eq("z_done", 64'(done), 64'h1);
        check_eq("z_busy", 64'(busy), 64'h0);
        repeat (4) @(negedge clk);
        check_eq("z_reqs", 64'(req_cnt - r0), 64'd0);
        check_eq("z_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Asynchronous reset during MEM_READ, then a normal read
        ack_en = 1'b0;
        start_xfer(1'b1, 32'h600, 27'd4);
        check_eq("rr_req_up", 64'(mem_request), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rr_req_async", 64'(mem_request), 64'h0);
        check_eq("rr_busy_async", 64'(busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        exp_rd_addr.push_back(32'h10);
        rd_data_q.push_back(16'hBEEF);
        exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
        d0 = done_cnt; r0 = req_cnt;
        start_xfer(1'b1, 32'h10, 27'd2);
        wait_done("rr", d0, 200);
        repeat (4) @(negedge clk);
        check_eq("rr_reqs", 64'(req_cnt - r0), 64'd1);
        check_eq("rr_tx_left", 64'(exp_tx.size()), 64'd0);
        check_eq("rr_rem", 64'(remaining), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
